// File: rtl/matrix_pkg.sv
// Shared definitions for the matrix accelerator's load/store stages: shape encoding,
// block geometry and the write_matrix FSM states.
package matrix_pkg;

  localparam int BLK_CNT  = 4;
  localparam int ROW_CNT  = 8;
  localparam int COL_CNT  = 8;
  localparam int ELEM_CNT = 256;
  localparam int DATA_W   = 32;

  localparam logic [1:0] MT_M8N32  = 2'd0;
  localparam logic [1:0] MT_M16N16 = 2'd1;
  localparam logic [1:0] MT_M32N8  = 2'd2;

  localparam logic [7:0] HDR_MAGIC = 8'hA5;
  localparam logic [8:0] LAST_IDX  = 9'(ELEM_CNT - 1);

`ifdef WRITE_MATRIX_HEADER_EN
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_SEND   = 3'd1,
    ST_RESP   = 3'd2,
    ST_DONE   = 3'd3,
    ST_HEADER = 3'd4
  } state_t;
`else
  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_SEND = 3'd1,
    ST_RESP = 3'd2,
    ST_DONE = 3'd3
  } state_t;
`endif

endpackage

// File: rtl/matrix_idx_map.sv
// Maps a logical row-major element index to (block, row, col) for the given shape.
// Reserved shape code 3 falls back to the m16n16 layout.
module matrix_idx_map
  import matrix_pkg::*;
(
  input  logic [1:0] mtype,
  input  logic [7:0] idx,
  output logic [1:0] blk,
  output logic [2:0] row,
  output logic [2:0] col
);

  // Every shape keeps 8-wide columns inside a block, so col is always the low bits.
  always_comb begin
    col = idx[2:0];
    blk = {idx[7], idx[3]};
    row = idx[6:4];
    case (mtype)
      MT_M8N32: begin
        blk = idx[4:3];
        row = idx[7:5];
      end
      MT_M32N8: begin
        blk = idx[7:6];
        row = idx[5:3];
      end
      default: begin
        blk = {idx[7], idx[3]};
        row = idx[6:4];
      end
    endcase
  end

endmodule

// File: rtl/write_matrix.sv
// Serialises result matrix D onto an AXI W/B channel in logical row-major order.
// Optional leading header beat when WRITE_MATRIX_HEADER_EN is defined.
module write_matrix
  import matrix_pkg::*;
(
  input  logic              clk,
  input  logic              rstn,
  input  logic              writestart,
  input  logic [1:0]        Matrix_type,
  input  logic [DATA_W-1:0] Matrix_D [0:BLK_CNT-1][0:ROW_CNT-1][0:COL_CNT-1],
  output logic [DATA_W-1:0] wdata,
  output logic              wvalid,
  output logic              wlast,
  input  logic              wready,
  input  logic [1:0]        bresp,
  input  logic              bvalid,
  output logic              bready,
  output logic              writedone,
  output logic              wr_err,
  output state_t            dbg_state
);

  // Handshake: a W beat moves on a cycle where wvalid && wready; wvalid, wdata and
  // wlast hold until then. A response moves where bready && bvalid (RESP only).

  state_t            state, state_d;
  logic [8:0]        idx, idx_d, idx_inc;
  logic [1:0]        type_q, type_d;
  logic [DATA_W-1:0] wdata_d, elem;
  logic              wvalid_d, wlast_d, bready_d, writedone_d, wr_err_d;
  logic              beat_xfer;
  logic [1:0]        map_type, map_blk;
  logic [7:0]        map_idx;
  logic [2:0]        map_row, map_col;

  assign beat_xfer = wvalid && wready;
  assign idx_inc   = idx + 9'd1;
  assign dbg_state = state;

  // Data is prefetched one beat ahead: in IDLE/HEADER fetch element 0 with the
  // shape about to be used, in SEND fetch the element after the current one.
  assign map_type = (state == ST_IDLE) ? Matrix_type : type_q;
  assign map_idx  = (state == ST_SEND) ? idx_inc[7:0] : 8'd0;

  matrix_idx_map u_idx_map (
    .mtype (map_type),
    .idx   (map_idx),
    .blk   (map_blk),
    .row   (map_row),
    .col   (map_col)
  );

  assign elem = Matrix_D[map_blk][map_row][map_col];

  always_comb begin
    state_d     = state;
    idx_d       = idx;
    type_d      = type_q;
    wdata_d     = wdata;
    wvalid_d    = wvalid;
    wlast_d     = wlast;
    bready_d    = 1'b0;
    writedone_d = 1'b0;
    wr_err_d    = wr_err;
    case (state)
      ST_IDLE: begin
        if (writestart) begin
          type_d   = Matrix_type;
          idx_d    = 9'd0;
          wr_err_d = 1'b0;
          wvalid_d = 1'b1;
          wlast_d  = 1'b0;
`ifdef WRITE_MATRIX_HEADER_EN
          state_d  = ST_HEADER;
          wdata_d  = {HDR_MAGIC, 22'b0, Matrix_type};
`else
          state_d  = ST_SEND;
          wdata_d  = elem;
`endif
        end
      end
`ifdef WRITE_MATRIX_HEADER_EN
      ST_HEADER: begin
        if (beat_xfer) begin
          state_d = ST_SEND;
          wdata_d = elem;
          wlast_d = 1'b0;
        end
      end
`endif
      ST_SEND: begin
        if (beat_xfer) begin
          idx_d = idx_inc;
          if (idx == LAST_IDX) begin
            state_d  = ST_RESP;
            wvalid_d = 1'b0;
            wlast_d  = 1'b0;
            bready_d = 1'b1;
          end else begin
            wdata_d = elem;
            wlast_d = (idx_inc == LAST_IDX);
          end
        end
      end
      ST_RESP: begin
        bready_d = 1'b1;
        if (bvalid) begin
          bready_d    = 1'b0;
          writedone_d = 1'b1;
          wr_err_d    = wr_err | (bresp != 2'b00);
          state_d     = ST_DONE;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state     <= ST_IDLE;
      idx       <= 9'd0;
      type_q    <= MT_M8N32;
      wdata     <= '0;
      wvalid    <= 1'b0;
      wlast     <= 1'b0;
      bready    <= 1'b0;
      writedone <= 1'b0;
      wr_err    <= 1'b0;
    end else begin
      state     <= state_d;
      idx       <= idx_d;
      type_q    <= type_d;
      wdata     <= wdata_d;
      wvalid    <= wvalid_d;
      wlast     <= wlast_d;
      bready    <= bready_d;
      writedone <= writedone_d;
      wr_err    <= wr_err_d;
    end
  end

endmodule

// File: tb/tb_write_matrix.sv
// Bench for write_matrix: directed runs per shape, stalls, error response, reset abort.
module tb_write_matrix;
  import matrix_pkg::*;

`ifdef WRITE_MATRIX_HEADER_EN
  localparam int HDR = 1;
`else
  localparam int HDR = 0;
`endif

  // ---------------- clock / reset ----------------
  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        writestart = 1'b0;
  logic [1:0]  Matrix_type = 2'd0;
  logic [31:0] Matrix_D [0:3][0:7][0:7];
  logic [31:0] wdata;
  logic        wvalid, wlast, bready, writedone, wr_err;
  logic        wready = 1'b1;
  logic [1:0]  bresp = 2'b00;
  logic        bvalid = 1'b0;
  state_t      dbg_state;

  always #5 clk = ~clk;

  int cyc = 0;
  initial forever begin
    @(posedge clk);
    cyc++;
  end

  write_matrix dut (
    .clk         (clk),
    .rstn        (rstn),
    .writestart  (writestart),
    .Matrix_type (Matrix_type),
    .Matrix_D    (Matrix_D),
    .wdata       (wdata),
    .wvalid      (wvalid),
    .wlast       (wlast),
    .wready      (wready),
    .bresp       (bresp),
    .bvalid      (bvalid),
    .bready      (bready),
    .writedone   (writedone),
    .wr_err      (wr_err),
    .dbg_state   (dbg_state)
  );

  // ---------------- checking ----------------
  int chk_cnt = 0;
  int pass_cnt = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    chk_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
  endtask

  // Independent arithmetic model: logical (r, c) -> block-of-8x8 layout.
  function automatic logic [31:0] model_elem(input logic [1:0] t, input int i);
    int n, r, c, b;
    n = (t == 2'd0) ? 32 : (t == 2'd2) ? 8 : 16;
    r = i / n;
    c = i % n;
    b = (r / 8) * (n / 8) + c / 8;
    return {8'd0, 8'(b), 8'(r % 8), 8'(c % 8)};
  endfunction

  // ---------------- scoreboard / monitor ----------------
  logic [31:0] exp_q[$];
  logic [31:0] cap [0:255];
  logic [31:0] hdr_cap = '0;
  logic [31:0] stall_data = '0;
  logic        stall_last = 1'b0;
  logic        stall_q = 1'b0;
  logic        mon_en = 1'b0;
  int          beat_n = 0;
  int          done_cyc = -1;
  int          t0 = 0;

  initial forever begin
    @(negedge clk);
    if (mon_en) begin
      if (stall_q) begin
        check("stall_wvalid", 32'(wvalid), 32'd1);
        check("stall_wdata", wdata, stall_data);
        check("stall_wlast", 32'(wlast), 32'(stall_last));
      end
      if (wvalid && wready) begin
        if (exp_q.size() == 0) begin
          check("beat_overflow", 32'(beat_n), 32'(HDR + 256));
        end else begin
          check("beat_data", wdata, exp_q.pop_front());
          check("beat_last", 32'(wlast), 32'(beat_n == HDR + 255));
        end
        if (beat_n < HDR) hdr_cap = wdata;
        else if (beat_n < HDR + 256) cap[beat_n - HDR] = wdata;
        beat_n++;
      end
      stall_q    = wvalid && !wready;
      stall_data = wdata;
      stall_last = wlast;
      if (writedone && done_cyc < 0) done_cyc = cyc;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic start_run(input logic [1:0] t, input logic [1:0] br);
    exp_q.delete();
    if (HDR == 1) exp_q.push_back({8'hA5, 22'b0, t});
    for (int i = 0; i < 256; i++) exp_q.push_back(model_elem(t, i));
    beat_n   = 0;
    done_cyc = -1;
    stall_q  = 1'b0;
    mon_en   = 1'b1;
    @(posedge clk); #1;
    Matrix_type = t;
    bresp       = br;
    bvalid      = 1'b1;
    writestart  = 1'b1;
    t0          = cyc;
    @(posedge clk); #1;
    writestart = 1'b0;
    check("wvalid_rise", 32'(wvalid), 32'd1);
    check("wr_err_cleared", 32'(wr_err), 32'd0);
  endtask

  task automatic finish_run(input bit rand_rdy, input int poke_at, output int lat);
    int n = 0;
    while (done_cyc < 0 && n < 3000) begin
      wready     = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
      writestart = (n == poke_at);
      @(posedge clk); #1;
      n++;
    end
    writestart = 1'b0;
    wready     = 1'b1;
    if (done_cyc < 0) check("done_timeout", 32'd0, 32'd1);
    lat = done_cyc - t0;
    check("writedone_pulse", 32'(writedone), 32'd0);
    check("idle_after_done", 32'(dbg_state), 32'(ST_IDLE));
    check("beat_count", 32'(beat_n), 32'(HDR + 256));
    check("sb_empty", 32'(exp_q.size()), 32'd0);
  endtask

  // ---------------- vectors ----------------
  typedef struct {
    logic [1:0]  mt;
    int          beat;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs [0:11];

  task automatic check_table(input logic [1:0] t);
    for (int i = 0; i < 12; i++) begin
      if (vecs[i].mt == t) check($sformatf("vec%0d_t%0d_b%0d", i, t, vecs[i].beat), cap[vecs[i].beat], vecs[i].exp);
    end
  endtask

  initial begin
    int lat;
    int n;
    vecs[0]  = '{2'd1, 8,   32'h0001_0000};
    vecs[1]  = '{2'd1, 16,  32'h0000_0100};
    vecs[2]  = '{2'd1, 0,   32'h0000_0000};
    vecs[3]  = '{2'd1, 17,  32'h0000_0101};
    vecs[4]  = '{2'd1, 136, 32'h0003_0000};
    vecs[5]  = '{2'd1, 255, 32'h0003_0707};
    vecs[6]  = '{2'd0, 31,  32'h0003_0007};
    vecs[7]  = '{2'd0, 8,   32'h0001_0000};
    vecs[8]  = '{2'd0, 32,  32'h0000_0100};
    vecs[9]  = '{2'd2, 64,  32'h0001_0000};
    vecs[10] = '{2'd2, 255, 32'h0003_0707};
    vecs[11] = '{2'd2, 9,   32'h0000_0101};
    for (int b = 0; b < 4; b++)
      for (int r = 0; r < 8; r++)
        for (int c = 0; c < 8; c++)
          Matrix_D[b][r][c] = {8'd0, 8'(b), 8'(r), 8'(c)};
    for (int i = 0; i < 256; i++) cap[i] = '0;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_wvalid", 32'(wvalid), 32'd0);
    check("rst_wlast", 32'(wlast), 32'd0);
    check("rst_bready", 32'(bready), 32'd0);
    check("rst_writedone", 32'(writedone), 32'd0);
    check("rst_wr_err", 32'(wr_err), 32'd0);
    check("rst_wdata", wdata, 32'd0);
    check("rst_state", 32'(dbg_state), 32'(ST_IDLE));
    rstn = 1'b1;

    // Full-rate runs for each shape
    for (int t = 0; t < 3; t++) begin
      logic [1:0] tt;
      tt = (t == 0) ? 2'd1 : (t == 1) ? 2'd0 : 2'd2;
      start_run(tt, 2'b00);
      finish_run(1'b0, -1, lat);
      check($sformatf("latency_t%0d", tt), 32'(lat), 32'(258 + HDR));
      check("wr_err_ok", 32'(wr_err), 32'd0);
      check_table(tt);
`ifdef WRITE_MATRIX_HEADER_EN
      check("hdr_beat", hdr_cap, {8'hA5, 22'b0, tt});
`endif
    end

    // Random stalls, writestart poked mid-SEND, error response
    start_run(2'd1, 2'b10);
    finish_run(1'b1, 40, lat);
    check("wr_err_set", 32'(wr_err), 32'd1);
    check_table(2'd1);

    // Clean run after the error clears wr_err at start
    start_run(2'd0, 2'b00);
    finish_run(1'b1, -1, lat);
    check("wr_err_clean", 32'(wr_err), 32'd0);
    check_table(2'd0);

    // Reset once beat 100 has transferred
    start_run(2'd1, 2'b00);
    n = 0;
    while (beat_n < 101 && n < 500) begin
      @(posedge clk); #1;
      n++;
    end
    check("reach_beat100", 32'(beat_n), 32'd101);
    mon_en = 1'b0;
    rstn   = 1'b0;
    @(posedge clk); #1;
    check("abort_wvalid", 32'(wvalid), 32'd0);
    check("abort_wlast", 32'(wlast), 32'd0);
    check("abort_bready", 32'(bready), 32'd0);
    check("abort_writedone", 32'(writedone), 32'd0);
    check("abort_wdata", wdata, 32'd0);
    check("abort_state", 32'(dbg_state), 32'(ST_IDLE));
    rstn = 1'b1;

    // Restart from beat 0 after the abort
    start_run(2'd2, 2'b00);
    finish_run(1'b0, -1, lat);
    check("restart_latency", 32'(lat), 32'(258 + HDR));
    check_table(2'd2);

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule

// File: doc/write_matrix.md
# write_matrix

Downstream result stage of the matrix accelerator. After compute completes, it serialises the 256-element result matrix D (four 8×8 blocks) onto an AXI write-data/response channel, in logical row-major order for the active `Matrix_type`. It waits for a single write response and pulses `writedone`. It is the mirror of the input matrix loader and uses the same block layout and `Matrix_type` encoding.

## Interface
- No parameters; dimensions fixed in `matrix_pkg`.
- `clk` in 1: clock.
- `rstn` in 1: reset, asynchronous, active-low.
- `writestart` in 1: start pulse; sampled only in IDLE.
- `Matrix_type` in 2: 0 = m8n32, 1 = m16n16, 2 = m32n8, 3 = reserved (treated as 1).
- `Matrix_D` in 32×[0:3][0:7][0:7]: result blocks; must be held stable from `writestart` until `writedone`.
- `wdata` out 32: beat data.
- `wvalid` out 1: beat valid.
- `wlast` out 1: high on final beat.
- `wready` in 1: sink accepts beat.
- `bresp` in 2: write response code.
- `bvalid` in 1: response valid.
- `bready` out 1: response accept.
- `writedone` out 1: one-cycle completion pulse.
- `wr_err` out 1: sticky; set when `bresp != 0`.

## Operation
- States: IDLE, SEND, RESP, DONE, plus HEADER when `WRITE_MATRIX_HEADER_EN` is defined.
- IDLE: on `writestart`, clear `wr_err` and beat counter `idx` (9 bits), latch `Matrix_type` into `type_q`, then go to HEADER or SEND. `writestart` is ignored in every other state.
- SEND: `wvalid` = 1; `wdata` = D element at logical index `idx`; `r = idx / N`, `c = idx % N`.
- Shape per `type_q`:
  - 0 (m8n32): N = 32; blk = c>>3, row = r, col = c[2:0].
  - 1 (m16n16): N = 16; blk = {r[3], c[3]}, row = r[2:0], col = c[2:0].
  - 2 (m32n8): N = 8; blk = r[4:3], row = r[2:0], col = c.
- A beat transfers when `wvalid && wready`; `idx` then increments.
- `wlast` = (`idx == 255`) in SEND.
- On the transfer with `idx == 255`, go to RESP.
- RESP: `bready` = 1. On `bvalid`, set `wr_err` if `bresp != 2'b00`, then go to DONE.
- DONE: `writedone` = 1 for one cycle, then go to IDLE.
- AXI rules:
  - Once `wvalid` rises it stays high until the handshake.
  - `wdata` and `wlast` are stable while `wvalid && !wready`.
  - `bvalid` seen outside RESP is ignored.
- Reset mid-transfer returns immediately to IDLE with all outputs at reset values. No partial completion is signalled.

## Timing
- Reset values: `wvalid` = 0, `wlast` = 0, `bready` = 0, `writedone` = 0, `wr_err` = 0, `wdata` = 0, state = IDLE, `idx` = 0.
- `wvalid`, `bready` and `writedone` are registered from the state. `wdata` and `wlast` are registered together with the `idx` advance.
- `writestart` at cycle T gives first `wvalid` at T+1.
- With `wready` held at 1: last beat at T+256; `bready` from T+257.
- `bvalid` at cycle R gives `writedone` at R+1. Minimum `writestart` → `writedone` is 258 cycles (259 with header).
- Back-to-back: a new `writestart` is accepted in the cycle after `writedone`.

## Configuration
- `WRITE_MATRIX_HEADER_EN` defined:
  - HEADER state sends one extra beat before the data: `wdata = {8'hA5, 22'b0, type_q}`, `wlast` = 0.
  - Total 257 beats; `idx` counts data beats only.
- Not defined: HEADER state and logic are absent; exactly 256 beats are sent.

## Structure
- `matrix_pkg` holds:
  - `Matrix_type` encoding constants (`MT_M8N32`, `MT_M16N16`, `MT_M32N8`).
  - Block, row and column dimensions (4, 8, 8).
  - `ELEM_CNT` = 256.
  - `HDR_MAGIC` = 8'hA5.
  - The state enum.
- One combinational sub-module, `matrix_idx_map`: maps (`type_q`, `idx`) to (blk, row, col). Shared with the input loader's write-address path.

## Test plan
- Type 1, `D[b][r][c] = {b, r, c}` pattern, `wready` = 1, `bresp` = 0 → 256 beats.
  - Beat 8 = D[1][0][0]; beat 16 = D[0][1][0].
  - `wlast` only on beat 255; `writedone` at start + 258; `wr_err` = 0.
- Type 0 and type 2 with the same pattern:
  - Type 0: beat 31 = D[3][0][7].
  - Type 2: beat 64 = D[1][0][0], beat 255 = D[3][7][7].
- Random `wready` (50 %) → `wdata` and `wlast` stable while stalled, no beat dropped or duplicated, exactly 256 handshakes.
- `bresp` = 2'b10 → `wr_err` = 1 after `writedone`.
  - A following run with `bresp` = 0 clears `wr_err` at `writestart`.
- `rstn` low at beat 100 → next cycle all outputs 0, state IDLE.
  - A new `writestart` then restarts from beat 0.
  - `writestart` pulsed during SEND has no effect.
- `WRITE_MATRIX_HEADER_EN`, type 2 → first beat 32'hA500_0002, then 256 data beats; `writedone` at start + 259.
